// File: rtl/pwl_activation_if.sv
// Sample/result stream and table-config bundle for the piecewise-linear activation unit.
// master drives samples and config and accepts results; slave is the activation unit.
interface pwl_activation_if #(
    parameter int DW = 32,
    parameter int AW = 6
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_slope;
    logic [DW-1:0] cfg_intercept;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        output cfg_we, cfg_addr, cfg_slope, cfg_intercept,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        input  cfg_we, cfg_addr, cfg_slope, cfg_intercept,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pwl_activation_pipe.sv
// Three-stage piecewise-linear activation: y = slope[seg]*x + intercept[seg], with a
// run-time programmable segment table shared by sigmoid and tanh (tanh(x) = 2*sig(2x) - 1).
module pwl_activation_pipe #(
    parameter  int DW       = 32,
    parameter  int FRAC     = 15,
    parameter  int SEG_BITS = 4,
    localparam int AW       = SEG_BITS + 2
) (
    input logic               clk,
    input logic               rst_n,
    pwl_activation_if.slave   bus
);
    localparam int DEPTH  = 2 ** (SEG_BITS + 1) + 2;
    localparam int SAT_HI = 2 ** (SEG_BITS + 1);
    localparam int SAT_LO = SAT_HI + 1;
    localparam int OB     = FRAC + SEG_BITS;
    localparam int SW     = 2 * DW + 2;

    localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [SW-1:0] ONE  = {{(SW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

    logic signed [DW-1:0] slope_tab [DEPTH];
    logic signed [DW-1:0] icpt_tab  [DEPTH];

    logic                 adv;
    logic                 v1, v2, out_valid_q;
    logic                 mode1, mode2, ovf1, ovf2;
    logic signed [DW-1:0] x1, x2, slope2, icpt2, out_data_q;
    logic [AW-1:0]        idx1;

    // Global stall: every stage moves together whenever the output slot is free.
    assign adv           = ~out_valid_q | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    logic signed [DW-1:0] x_in, x_dbl, x_n;
    logic                 pos_ovf, neg_ovf;
    logic [AW-1:0]        idx_n;

    always_comb begin
        x_in = $signed(bus.in_data);
        if (x_in[DW-1] != x_in[DW-2]) x_dbl = x_in[DW-1] ? DMIN : DMAX;
        else                          x_dbl = {x_in[DW-2:0], 1'b0};
        x_n     = bus.in_mode ? x_dbl : x_in;
        pos_ovf = ~x_n[DW-1] & (|x_n[DW-2:OB]);
        neg_ovf =  x_n[DW-1] & ~(&x_n[DW-2:OB]);
        if (pos_ovf)      idx_n = AW'(SAT_HI);
        else if (neg_ovf) idx_n = AW'(SAT_LO);
        else              idx_n = {1'b0, x_n[DW-1], x_n[OB-1:FRAC]};
    end

    // NOTE: this table is a bank of flops, not a RAM, because reset must clear every
    // entry in one cycle; a RAM macro could not be reset this way.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slope_tab[i] <= '0;
                icpt_tab[i]  <= '0;
            end
        end else if (bus.cfg_we && int'(bus.cfg_addr) < DEPTH) begin
            slope_tab[bus.cfg_addr] <= $signed(bus.cfg_slope);
            icpt_tab[bus.cfg_addr]  <= $signed(bus.cfg_intercept);
        end
    end

    logic signed [2*DW-1:0] prod;
    logic signed [SW-1:0]   s_lin, s_fin;
    logic signed [DW-1:0]   s_sat;

    always_comb begin
        prod  = slope2 * x2;
        s_lin = ovf2 ? SW'(icpt2) : SW'(prod >>> FRAC) + SW'(icpt2);
        s_fin = mode2 ? (s_lin <<< 1) - ONE : s_lin;
        if (s_fin > SW'(DMAX))      s_sat = DMAX;
        else if (s_fin < SW'(DMIN)) s_sat = DMIN;
        else                        s_sat = s_fin[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            mode1       <= 1'b0;
            mode2       <= 1'b0;
            ovf1        <= 1'b0;
            ovf2        <= 1'b0;
            x1          <= '0;
            x2          <= '0;
            idx1        <= '0;
            slope2      <= '0;
            icpt2       <= '0;
        end else if (adv) begin
            v1    <= bus.in_valid;
            x1    <= x_n;
            mode1 <= bus.in_mode;
            ovf1  <= ovf_n_q();
            idx1  <= idx_n;
            // NOTE: non-blocking assignment means this read sees the table before any
            // config write landing on the same edge, so a colliding write applies next edge.
            v2     <= v1;
            x2     <= x1;
            mode2  <= mode1;
            ovf2   <= ovf1;
            slope2 <= slope_tab[idx1];
            icpt2  <= icpt_tab[idx1];
            out_valid_q <= v2;
            if (v2) out_data_q <= s_sat;
        end
    end

    function automatic logic ovf_n_q();
        return pos_ovf | neg_ovf;
    endfunction
endmodule
